// File: rtl/spm_wb_ctrl.sv
// rtl/spm_wb_ctrl.sv - Wishbone register slave that sequences a serial-parallel multiplier
// Streams the multiplier LSB-first and deserialises the 2*WIDTH-bit product from spm_p.
module spm_wb_ctrl #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          SPM_LAT  = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             spm_clr,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    input  logic             spm_p,
    output logic             irq_o
);

    localparam int SHIFT_LEN = 2 * WIDTH + SPM_LAT;
    localparam int KW        = $clog2(SHIFT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             ack_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [63:0]      p_q;
    logic [KW-1:0]    k_q;
    logic             done_q;
    logic             busy_q;
    logic             irq_en_q;
    logic             spm_clr_q;
    logic             spm_y_q;

    logic             hit;
    logic             wr;
    logic [2:0]       reg_idx;
    logic             ctrl_wr;
    logic             start_req;
    logic [31:0]      x_wr;
    logic [31:0]      y_wr;
    logic [31:0]      rd_data;
    logic [KW-1:0]    k_next;
    logic [WIDTH-1:0] y_shift;
    logic             unused_adr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    assign hit        = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign wr         = hit && ack_q && wbs_we_i;
    assign reg_idx    = wbs_adr_i[4:2];
    assign ctrl_wr    = wr && (reg_idx == 3'd2) && wbs_sel_i[0];
    assign start_req  = ctrl_wr && wbs_dat_i[0] && !busy_q;
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        x_wr    = byte_merge(32'(x_q), wbs_dat_i, wbs_sel_i);
        y_wr    = byte_merge(32'(y_q), wbs_dat_i, wbs_sel_i);
        k_next  = k_q + KW'(1);
        // Shifting past WIDTH naturally yields 0 once the multiplier bits run out.
        y_shift = y_q >> k_next;
        case (reg_idx)
            3'd0:    rd_data = 32'(x_q);
            3'd1:    rd_data = 32'(y_q);
            3'd2:    rd_data = {28'd0, irq_en_q, busy_q, done_q, 1'b0};
            3'd3:    rd_data = p_q[31:0];
            3'd4:    rd_data = p_q[63:32];
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            spm_clr_q <= 1'b0;
            spm_y_q   <= 1'b0;
        end else begin
            ack_q     <= hit && !ack_q;
            spm_clr_q <= 1'b0;

            if (wr && reg_idx == 3'd0 && !busy_q) x_q <= x_wr[WIDTH-1:0];
            if (wr && reg_idx == 3'd1 && !busy_q) y_q <= y_wr[WIDTH-1:0];
            if (ctrl_wr) irq_en_q <= wbs_dat_i[3];
            if (ctrl_wr && wbs_dat_i[1]) done_q <= 1'b0;

            if (start_req) begin
                state_q   <= S_CLR;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                p_q       <= '0;
                k_q       <= '0;
                spm_clr_q <= 1'b1;
            end else begin
                case (state_q)
                    S_CLR: begin
                        state_q <= S_SHIFT;
                        spm_y_q <= y_q[0];
                    end
                    S_SHIFT: begin
                        // P was zeroed on START, so OR-ing in each serial bit suffices.
                        if (k_q >= KW'(SPM_LAT)) begin
                            p_q <= p_q | (64'(spm_p) << (k_q - KW'(SPM_LAT)));
                        end
                        k_q     <= k_next;
                        spm_y_q <= y_shift[0];
                        if (k_q == KW'(SHIFT_LEN - 1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            spm_y_q <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? rd_data : 32'd0;
    assign spm_clr   = spm_clr_q;
    assign spm_x     = x_q;
    assign spm_y     = spm_y_q;
    assign irq_o     = done_q && irq_en_q;

endmodule

// File: tb/tb_spm_wb_ctrl.sv
// tb/tb_spm_wb_ctrl.sv - directed self-checking bench for spm_wb_ctrl with a behavioural SPM
module tb_spm_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        spm_clr;
    logic [31:0] spm_x;
    logic        spm_y;
    logic        spm_p;
    logic        irq;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spm_wb_ctrl #(.WIDTH(32), .BASE_ADR(32'h3000_0000), .SPM_LAT(1)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .spm_clr   (spm_clr),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p),
        .irq_o     (irq)
    );

    // Bit-serial multiplier: product bit k appears one cycle after multiplier bit k.
    logic [127:0] acc;
    logic [127:0] acc_n;
    int           idx;
    initial begin
        acc   = '0;
        idx   = 0;
        spm_p = 1'b0;
    end
    always @(posedge clk) begin
        if (spm_clr) begin
            acc   <= '0;
            idx   <= 0;
            spm_p <= 1'b0;
        end else begin
            acc_n = acc + (spm_y ? (128'(spm_x) << idx) : 128'd0);
            acc   <= acc_n;
            spm_p <= acc_n[idx];
            idx   <= (idx < 127) ? idx + 1 : idx;
        end
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got;
        got  = 1'b0;
        adr  = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++;
            $display("FAIL wb_write_timeout adr=%h got no ack required ack", a);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        lat = 0;
        d   = 32'd0;
        adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin lat = i; d = rdat; break; end
        end
        if (lat == 0) begin
            total++;
            $display("FAIL wb_read_timeout adr=%h got no ack required ack", a);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] d;
        int          lat;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wb_read(BASE + 32'h8, d, lat);
            if (d[1]) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            total++;
            $display("FAIL done_timeout got DONE=0 required DONE=1");
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ack !== 1'b0)     $display("FAIL reset_ack got=%b exp=0", ack);     else passed++;
        total++; if (irq !== 1'b0)     $display("FAIL reset_irq got=%b exp=0", irq);     else passed++;
        total++; if (spm_clr !== 1'b0) $display("FAIL reset_clr got=%b exp=0", spm_clr); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 5; r++) begin
            wb_read(BASE + 32'(4 * r), d, lat);
            total++;
            if (d !== 32'd0) $display("FAIL reset_reg%0d got=%h exp=00000000", r, d);
            else passed++;
        end
    endtask

    task automatic test_basic_mul();
        logic [31:0] d;
        int          lat;
        wb_write(BASE + 32'h0, 32'h0000_0007, 4'hF);
        wb_write(BASE + 32'h4, 32'h0000_0005, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0001, 4'hF);
        // Last busy cycle is 65 edges after the START edge; DONE appears two edges later.
        repeat (64) @(posedge clk);
        #1;
        wb_read(BASE + 32'h8, d, lat);
        total++; if (d !== 32'h4) $display("FAIL basic_busy_last got=%h exp=00000004", d); else passed++;
        wb_read(BASE + 32'h8, d, lat);
        total++; if (d !== 32'h2) $display("FAIL basic_done got=%h exp=00000002", d); else passed++;
        wb_read(BASE + 32'hC, d, lat);
        total++; if (d !== 32'h23) $display("FAIL basic_p_lo got=%h exp=00000023", d); else passed++;
        wb_read(BASE + 32'h10, d, lat);
        total++; if (d !== 32'h0) $display("FAIL basic_p_hi got=%h exp=00000000", d); else passed++;
    endtask

    task automatic test_irq_max();
        logic [31:0] d;
        int          lat;
        wb_write(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF);
        wb_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0009, 4'hF);
        wait_done();
        total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else passed++;
        wb_read(BASE + 32'h10, d, lat);
        total++; if (d !== 32'hFFFF_FFFE) $display("FAIL max_p_hi got=%h exp=fffffffe", d); else passed++;
        wb_read(BASE + 32'hC, d, lat);
        total++; if (d !== 32'h0000_0001) $display("FAIL max_p_lo got=%h exp=00000001", d); else passed++;
        wb_write(BASE + 32'h8, 32'h0000_000A, 4'hF);
        total++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else passed++;
        wb_read(BASE + 32'h8, d, lat);
        total++; if (d !== 32'h8) $display("FAIL w1c_stat got=%h exp=00000008", d); else passed++;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d;
        int          lat;
        wb_write(BASE + 32'h8, 32'h0000_0000, 4'hF);
        wb_write(BASE + 32'h0, 32'h0000_0009, 4'hF);
        wb_write(BASE + 32'h4, 32'h0000_0006, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0001, 4'hF);
        wb_write(BASE + 32'h0, 32'h0000_1234, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0001, 4'hF);
        wait_done();
        wb_read(BASE + 32'hC, d, lat);
        total++; if (d !== 32'h36) $display("FAIL busy_p_lo got=%h exp=00000036", d); else passed++;
        wb_read(BASE + 32'h0, d, lat);
        total++; if (d !== 32'h9) $display("FAIL busy_x_frozen got=%h exp=00000009", d); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          lat;
        wb_write(BASE + 32'h8, 32'h0000_0002, 4'hF);
        wb_write(BASE + 32'h0, 32'h0000_0055, 4'hF);
        wb_write(BASE + 32'h4, 32'h0000_0033, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0001, 4'hF);
        repeat (21) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (spm_clr !== 1'b0) $display("FAIL midrst_clr got=%b exp=0", spm_clr); else passed++;
        total++; if (spm_y !== 1'b0)   $display("FAIL midrst_y got=%b exp=0", spm_y);     else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(BASE + 32'h8, d, lat);
        total++; if (d !== 32'h0) $display("FAIL midrst_stat got=%h exp=00000000", d); else passed++;
        wb_read(BASE + 32'hC, d, lat);
        total++; if (d !== 32'h0) $display("FAIL midrst_p_lo got=%h exp=00000000", d); else passed++;
        wb_write(BASE + 32'h0, 32'h0000_0003, 4'hF);
        wb_write(BASE + 32'h4, 32'h0000_0004, 4'hF);
        wb_write(BASE + 32'h8, 32'h0000_0001, 4'hF);
        wait_done();
        wb_read(BASE + 32'hC, d, lat);
        total++; if (d !== 32'd12) $display("FAIL midrst_rerun got=%h exp=0000000c", d); else passed++;
    endtask

    task automatic test_decode();
        logic [31:0] d;
        int          lat;
        bit          seen;
        wb_read(BASE + 32'h18, d, lat);
        total++; if (lat !== 1)    $display("FAIL off6_latency got=%0d exp=1", lat);    else passed++;
        total++; if (d !== 32'h0)  $display("FAIL off6_data got=%h exp=00000000", d);   else passed++;
        wb_write(BASE + 32'h0, 32'h0000_0000, 4'hF);
        wb_write(BASE + 32'h0, 32'hAABB_CCDD, 4'b0101);
        wb_read(BASE + 32'h0, d, lat);
        total++; if (d !== 32'h00BB_00DD) $display("FAIL sel_mask got=%h exp=00bb00dd", d); else passed++;
        seen = 1'b0;
        adr = BASE + 32'h20; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0;
        total++; if (seen !== 1'b0) $display("FAIL miss_ack got=%b exp=0", seen); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        adr = BASE + 32'h0; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1;
            pat[i] = ack;
        end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        total++; if (pat !== 4'b1010) $display("FAIL b2b_ack_pattern got=%b exp=1010", pat); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'd0; wdat = 32'd0;
        test_reset();
        test_basic_mul();
        test_irq_max();
        test_busy_ignore();
        test_reset_mid();
        test_decode();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
